// File: rtl/booth_uc.sv
// booth_uc: sequencing FSM for a radix-2 Booth multiplier (Q/A/M datapath).
// Optional feature macro: BOOTH_CYCLE_COUNT_EN adds the 8-bit Ciclos output
// holding the CARGA..DESPL cycle count of the last completed multiplication.
module booth_uc #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic       q0,
    input  logic       q_1,
    output logic       CargaM,
    output logic       CargaQ,
    output logic       InicA,
    output logic       CargaA,
    output logic       Resta,
    output logic       DesplazaA,
    output logic       DesplazaQ,
    output logic       Fin
`ifdef BOOTH_CYCLE_COUNT_EN
    ,
    output logic [7:0] Ciclos
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CARGA,
        S_EVAL,
        S_OP,
        S_DESPL,
        S_FIN
    } state_t;

    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_opsel;
    logic          w_last;

    assign w_last = (r_cnt == LAST_ITER);
    assign Resta  = r_opsel;

    // State, iteration counter, op-select and strobes; each strobe is
    // registered alongside the state it belongs to, so it is high exactly
    // while the FSM sits in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_opsel   <= 1'b0;
            CargaM    <= 1'b0;
            CargaQ    <= 1'b0;
            InicA     <= 1'b0;
            CargaA    <= 1'b0;
            DesplazaA <= 1'b0;
            DesplazaQ <= 1'b0;
            Fin       <= 1'b0;
        end else begin
            CargaM    <= 1'b0;
            CargaQ    <= 1'b0;
            InicA     <= 1'b0;
            CargaA    <= 1'b0;
            DesplazaA <= 1'b0;
            DesplazaQ <= 1'b0;
            Fin       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (inicio) begin
                        r_state <= S_CARGA;
                        CargaM  <= 1'b1;
                        CargaQ  <= 1'b1;
                        InicA   <= 1'b1;
                    end
                end
                S_CARGA: begin
                    r_cnt   <= '0;
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    case ({q0, q_1})
                        2'b10: begin
                            r_opsel <= 1'b1;
                            r_state <= S_OP;
                            CargaA  <= 1'b1;
                        end
                        2'b01: begin
                            r_opsel <= 1'b0;
                            r_state <= S_OP;
                            CargaA  <= 1'b1;
                        end
                        default: begin
                            r_state   <= S_DESPL;
                            DesplazaA <= 1'b1;
                            DesplazaQ <= 1'b1;
                        end
                    endcase
                end
                S_OP: begin
                    r_state   <= S_DESPL;
                    DesplazaA <= 1'b1;
                    DesplazaQ <= 1'b1;
                end
                S_DESPL: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= S_FIN;
                        Fin     <= 1'b1;
                    end else begin
                        r_state <= S_EVAL;
                    end
                end
                S_FIN: begin
                    if (inicio) begin
                        Fin <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BOOTH_CYCLE_COUNT_EN
    logic [7:0] r_cyc;
    logic [7:0] w_cyc_inc;

    assign w_cyc_inc = (r_cyc == 8'hFF) ? 8'hFF : r_cyc + 8'd1;

    // Busy-cycle counter; CARGA loads 1 (cleared, then counts itself) and
    // the DESPL->FIN edge latches the count including that final DESPL cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc  <= '0;
            Ciclos <= '0;
        end else begin
            case (r_state)
                S_CARGA: r_cyc <= 8'd1;
                S_EVAL,
                S_OP:    r_cyc <= w_cyc_inc;
                S_DESPL: begin
                    r_cyc <= w_cyc_inc;
                    if (w_last) begin
                        Ciclos <= w_cyc_inc;
                    end
                end
                default: r_cyc <= r_cyc;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_booth_uc.sv
// Self-checking bench for booth_uc: a behavioural Q/A/M datapath driven by
// the DUT strobes; results checked against arithmetic products, latency
// 1+2N+k and the Booth add/sub order derived from the multiplier bits.
module tb_booth_uc;

    localparam int N  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset, inicio, q0, q_1;
    logic CargaM, CargaQ, InicA, CargaA, Resta, DesplazaA, DesplazaQ, Fin;
`ifdef BOOTH_CYCLE_COUNT_EN
    logic [7:0] Ciclos;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] mcand, mplier;
    logic [4:0] A, M;
    logic [3:0] Q;
    logic       q1;

    booth_uc #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .q0       (q0),
        .q_1      (q_1),
        .CargaM   (CargaM),
        .CargaQ   (CargaQ),
        .InicA    (InicA),
        .CargaA   (CargaA),
        .Resta    (Resta),
        .DesplazaA(DesplazaA),
        .DesplazaQ(DesplazaQ),
        .Fin      (Fin)
`ifdef BOOTH_CYCLE_COUNT_EN
        ,
        .Ciclos   (Ciclos)
`endif
    );

    always #5 clk = ~clk;

    assign q0  = Q[0];
    assign q_1 = q1;

    // Behavioural datapath; A carries one guard bit so every multiplicand works.
    always @(posedge clk) begin
        if (CargaM) M <= {mcand[3], mcand};
        if (CargaQ) begin
            Q  <= mplier;
            q1 <= 1'b0;
        end
        if (InicA) A <= '0;
        if (CargaA) A <= Resta ? A - M : A + M;
        if (DesplazaA) begin
            A  <= {A[4], A[4:1]};
            Q  <= {A[0], Q[3:1]};
            q1 <= Q[0];
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int strobes();
        return int'({CargaM, CargaQ, InicA, CargaA, Resta, DesplazaA, DesplazaQ, Fin});
    endfunction

    task automatic run_mult(input int mc, input int mp, input bit hold);
        int   k = 0;
        int   cycles = 0;
        int   nshift = 0;
        int   overlap = 0;
        int   shdiff = 0;
        int   exp_resta[$];
        int   obs_resta[$];
        logic [3:0] b;
        logic prev;
        int   p;
        b    = 4'(mp);
        prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (b[i] != prev) begin
                k++;
                exp_resta.push_back(int'(b[i]));
            end
            prev = b[i];
        end
        mcand  = 4'(mc);
        mplier = b;
        @(negedge clk) inicio = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) inicio = 1'b0;
        chk("carga_strobes", int'({CargaM, CargaQ, InicA}), 7);
        while (!Fin && cycles < 100) begin
            if (CargaA) obs_resta.push_back(int'(Resta));
            if (DesplazaA) nshift++;
            if (CargaA && DesplazaA) overlap++;
            if (DesplazaA != DesplazaQ) shdiff++;
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("fin_seen", int'(Fin), 1);
        chk("latency", cycles, 1 + 2 * N + k);
        chk("n_op", obs_resta.size(), k);
        for (int i = 0; i < exp_resta.size() && i < obs_resta.size(); i++)
            chk("resta_order", obs_resta[i], exp_resta[i]);
        chk("n_shift", nshift, N);
        chk("adds_shift_overlap", overlap, 0);
        chk("shiftA_vs_shiftQ", shdiff, 0);
        p = mc * mp;
        chk("product", int'({A[3:0], Q}), p & 255);
`ifdef BOOTH_CYCLE_COUNT_EN
        chk("ciclos", int'(Ciclos), 1 + 2 * N + k);
`endif
        if (hold) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                chk("fin_hold", int'(Fin), 1);
                chk("no_restart", int'(CargaQ), 0);
            end
            @(negedge clk) inicio = 1'b0;
            @(posedge clk);
            #1;
            chk("fin_drop_after_hold", int'(Fin), 0);
        end else begin
            @(posedge clk);
            #1;
            chk("fin_drop", int'(Fin), 0);
        end
    endtask

    initial begin
        int nop;
        reset  = 1'b1;
        inicio = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", strobes(), 0);
`ifdef BOOTH_CYCLE_COUNT_EN
        chk("reset_ciclos", int'(Ciclos), 0);
`endif
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("idle_quiet", strobes(), 0);
        end

        run_mult(5, 0, 1'b0);
        run_mult(-3, 5, 1'b0);
        run_mult(7, 6, 1'b0);
        run_mult(-8, -8, 1'b0);
        run_mult(6, -7, 1'b1);
        run_mult(-5, 3, 1'b0);

        // Reset during the second OP cycle.
        @(negedge clk) inicio = 1'b1;
        mcand  = 4'd3;
        mplier = 4'b0101;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        nop = 0;
        for (int i = 0; i < 40 && nop < 2; i++) begin
            if (CargaA) nop++;
            if (nop < 2) begin
                @(posedge clk);
                #1;
            end
        end
        chk("reached_second_op", nop, 2);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_midop", strobes(), 0);
`ifdef BOOTH_CYCLE_COUNT_EN
        chk("reset_midop_ciclos", int'(Ciclos), 0);
`endif
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("idle_after_reset", strobes(), 0);
        end
        run_mult(4, -6, 1'b0);

        for (int t = 0; t < 12; t++) begin
            int mc, mp;
            mc = int'($urandom_range(15, 0)) - 8;
            mp = int'($urandom_range(15, 0)) - 8;
            run_mult(mc, mp, ($urandom_range(3, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
